// File: rtl/cpu_ram_arbiter.sv
// cpu_ram_arbiter
//
// Front end for the 2 KB main-CPU work RAM. Three requesters share the one
// synchronous RAM port:
//   - the 6809 CPU bus, which always wins and is never stalled,
//   - a host/bridge port used for high-score save/load and debug peek/poke,
//     slotted into cycles the CPU leaves idle,
//   - a hardware clear sweep that zero-fills the whole RAM.
//
// Ports
//   clk, reset_n        system clock (shared with the RAM), async active-low reset
//   cpu_req/we/addr/wdata   one-cycle CPU access strobe and its fields
//   cpu_rdata, cpu_rvalid   CPU read data (straight from ram_q) and its valid pulse
//   host_req/we/addr/wdata  level host request, fields stable until host_ack
//   host_rdata, host_ack    registered host read data and completion pulse
//   clear_start, clear_busy zero-fill sweep trigger and busy flag
//   ram_address/write/data  to the RAM
//   ram_q                   from the RAM, one-cycle registered read latency
module cpu_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_RD  = 2'd1,
        HOST_ACK = 2'd2,
        CLEAR    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   counter_q, counter_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;

    logic                host_grant;
    logic                clear_write;

    // The host only gets the port in IDLE when nobody else wants it; a
    // simultaneous clear_start takes precedence and the host retries later.
    assign host_grant  = (state_q == IDLE) && host_req && !cpu_req && !clear_start;
    // The sweep writes only in cycles the CPU leaves free.
    assign clear_write = (state_q == CLEAR) && !cpu_req;

    assign cpu_rdata  = ram_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = (state_q == HOST_ACK);
    assign clear_busy = (state_q == CLEAR);

    // RAM port mux: CPU, then host grant, then the clear sweep; an idle
    // port drives all zeros so nothing stray is written.
    always_comb begin
        ram_address = '0;
        ram_write   = 1'b0;
        ram_data    = '0;
        if (cpu_req) begin
            ram_address = cpu_addr;
            ram_write   = cpu_we;
            ram_data    = cpu_wdata;
        end else if (host_grant) begin
            ram_address = host_addr;
            ram_write   = host_we;
            ram_data    = host_wdata;
        end else if (clear_write) begin
            ram_address = counter_q;
            ram_write   = 1'b1;
        end
    end

    // Next-state logic. HOST_RD captures ram_q even for host writes, which
    // returns whatever the RAM reads during a write cycle.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        host_rdata_d = host_rdata_q;
        cpu_rvalid_d = cpu_req && !cpu_we;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    counter_d = '0;
                end else if (host_grant) begin
                    state_d = HOST_RD;
                end
            end
            HOST_RD: begin
                host_rdata_d = ram_q;
                state_d      = HOST_ACK;
            end
            HOST_ACK: begin
                state_d = IDLE;
            end
            CLEAR: begin
                if (!cpu_req) begin
                    counter_d = counter_q + ADDR_W'(1);
                    if (counter_q == '1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            host_rdata_q <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            host_rdata_q <= host_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

endmodule
